wb_stage: RTL and testbench

Writeback stage of the ysyx_22050550 five-stage core. It sits directly downstream of the load/store stage. It registers the LSU→WB bundle in a one-entry pipeline register, selects the writeback value and drives the register-file write port and the forwarding (bypass) port. It also emits a one-cycle commit record for difftest, counts retired instructions, and enters a sticky halt state on `ebreak`.

---
 rtl/wb_stage.sv | 123 ++++++++++++
 tb/tb_wb_stage.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: registers the LSU bundle, drives the register-file write
// port, the bypass port, the commit record, the retire counter and the ebreak halt.
module wb_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        ls_valid,
    input  logic        ls_flush,
    input  logic [63:0] ls_pc,
    input  logic [31:0] ls_inst,
    input  logic [63:0] ls_nextpc,
    input  logic [4:0]  ls_wdaddr,
    input  logic        ls_wen,
    input  logic        ls_readflag,
    input  logic        ls_csrflag,
    input  logic [63:0] ls_alures,
    input  logic [63:0] ls_lsures,
    input  logic [63:0] csr_rdata,
    input  logic        ls_ebreak,
    input  logic        ls_skipref,
    output logic        ready_ls,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic        byp_valid,
    output logic [4:0]  byp_addr,
    output logic [63:0] byp_data,
    output logic        commit_valid,
    output logic [63:0] commit_pc,
    output logic [31:0] commit_inst,
    output logic [63:0] commit_nextpc,
    output logic        commit_skipref,
    output logic        halted,
    output logic [63:0] halt_pc,
    output logic [63:0] instret
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        accept;
    logic [63:0] wd_d;

    logic        v_q;
    logic [63:0] pc_q;
    logic [31:0] inst_q;
    logic [63:0] nextpc_q;
    logic [4:0]  waddr_q;
    logic        wen_q;
    logic [63:0] wd_q;
    logic        skipref_q;
    logic [63:0] halt_pc_q;
    logic [63:0] instret_q;

    always_comb begin
        state_d  = state_q;
        ready_ls = (state_q == RUN);
        halted   = (state_q == HALT);
        accept   = ls_valid & ready_ls & ~ls_flush;
        if (accept && ls_ebreak) begin
            state_d = HALT;
        end
    end

    // A load takes priority over a CSR read if both flags are raised.
    always_comb begin
        wd_d = ls_alures;
        if (ls_readflag) begin
            wd_d = ls_lsures;
        end else if (ls_csrflag) begin
            wd_d = csr_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            v_q       <= 1'b0;
            pc_q      <= '0;
            inst_q    <= '0;
            nextpc_q  <= '0;
            waddr_q   <= '0;
            wen_q     <= 1'b0;
            wd_q      <= '0;
            skipref_q <= 1'b0;
            halt_pc_q <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            v_q       <= accept;
            instret_q <= instret_q + {63'd0, v_q};
            if (accept) begin
                pc_q      <= ls_pc;
                inst_q    <= ls_inst;
                nextpc_q  <= ls_nextpc;
                waddr_q   <= ls_wdaddr;
                wen_q     <= ls_wen;
                wd_q      <= wd_d;
                skipref_q <= ls_skipref;
            end
            if (accept && ls_ebreak) begin
                halt_pc_q <= ls_pc;
            end
        end
    end

    assign rf_wen         = v_q & wen_q & (waddr_q != 5'd0);
    assign rf_waddr       = waddr_q;
    assign rf_wdata       = wd_q;
    assign byp_valid      = rf_wen;
    assign byp_addr       = waddr_q;
    assign byp_data       = wd_q;
    assign commit_valid   = v_q;
    assign commit_pc      = pc_q;
    assign commit_inst    = inst_q;
    assign commit_nextpc  = nextpc_q;
    assign commit_skipref = skipref_q;
    assign halt_pc        = halt_pc_q;
    assign instret        = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        ls_valid, ls_flush, ls_wen, ls_readflag, ls_csrflag;
    logic        ls_ebreak, ls_skipref;
    logic [63:0] ls_pc, ls_nextpc, ls_alures, ls_lsures, csr_rdata;
    logic [31:0] ls_inst;
    logic [4:0]  ls_wdaddr;
    logic        ready_ls, rf_wen, byp_valid, commit_valid, commit_skipref, halted;
    logic [4:0]  rf_waddr, byp_addr;
    logic [63:0] rf_wdata, byp_data, commit_pc, commit_nextpc, halt_pc, instret;
    logic [31:0] commit_inst;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit          m_halted;
    logic [63:0] m_halt_pc, m_cnt;
    bit          e_v, e_wen, e_skip;
    logic [4:0]  e_waddr;
    logic [63:0] e_wd, e_pc, e_npc;
    logic [31:0] e_inst;

    always #5 clock = ~clock;

    wb_stage dut (
        .clock(clock), .reset(reset),
        .ls_valid(ls_valid), .ls_flush(ls_flush), .ls_pc(ls_pc),
        .ls_inst(ls_inst), .ls_nextpc(ls_nextpc), .ls_wdaddr(ls_wdaddr),
        .ls_wen(ls_wen), .ls_readflag(ls_readflag), .ls_csrflag(ls_csrflag),
        .ls_alures(ls_alures), .ls_lsures(ls_lsures), .csr_rdata(csr_rdata),
        .ls_ebreak(ls_ebreak), .ls_skipref(ls_skipref),
        .ready_ls(ready_ls), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .byp_valid(byp_valid), .byp_addr(byp_addr),
        .byp_data(byp_data), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_inst(commit_inst), .commit_nextpc(commit_nextpc),
        .commit_skipref(commit_skipref), .halted(halted), .halt_pc(halt_pc),
        .instret(instret)
    );

    task automatic idle();
        ls_valid = 0; ls_flush = 0; ls_pc = 0; ls_inst = 0; ls_nextpc = 0;
        ls_wdaddr = 0; ls_wen = 0; ls_readflag = 0; ls_csrflag = 0;
        ls_alures = 0; ls_lsures = 0; csr_rdata = 0; ls_ebreak = 0;
        ls_skipref = 0;
    endtask

    task automatic set_op(input logic [63:0] pc, input logic [4:0] rd,
                          input logic wen, input logic [63:0] alu);
        ls_valid = 1; ls_flush = 0; ls_pc = pc; ls_inst = $urandom;
        ls_nextpc = pc + 64'd4; ls_wdaddr = rd; ls_wen = wen;
        ls_readflag = 0; ls_csrflag = 0; ls_alures = alu;
        ls_lsures = {$urandom, $urandom}; csr_rdata = {$urandom, $urandom};
        ls_ebreak = 0; ls_skipref = 0;
    endtask

    // Predict the effect of the current inputs, then advance one clock.
    task automatic tick();
        bit acc;
        acc = ls_valid && !m_halted && !ls_flush;
        if (reset) begin
            m_halted = 0; m_halt_pc = 0; m_cnt = 0; e_v = 0;
        end else begin
            if (e_v) m_cnt = m_cnt + 64'd1;
            e_v = acc;
            if (acc) begin
                e_pc = ls_pc; e_inst = ls_inst; e_npc = ls_nextpc;
                e_waddr = ls_wdaddr; e_wen = ls_wen; e_skip = ls_skipref;
                if (ls_readflag) e_wd = ls_lsures;
                else if (ls_csrflag) e_wd = csr_rdata;
                else e_wd = ls_alures;
                if (ls_ebreak) begin
                    m_halted = 1; m_halt_pc = ls_pc;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; idle(); tick(); tick(); reset = 0;
    endtask

    task automatic test_reset();
        set_op(64'h8000_0000, 5'd3, 1, 64'h1234);
        ls_ebreak = 1;
        tick();
        reset = 1;
        set_op(64'h8000_0004, 5'd4, 1, 64'h5678);
        tick();
        reset = 0; idle();
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata, byp_valid, byp_addr, byp_data,
             commit_valid, commit_pc, commit_inst, commit_nextpc,
             commit_skipref, halted, halt_pc, instret} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got nonzero outputs rf_wen=%0b commit_valid=%0b halted=%0b instret=%0d halt_pc=%h, want all 0",
                     rf_wen, commit_valid, halted, instret, halt_pc);
        end
        n_cmp++;
        if (ready_ls !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", ready_ls);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_op(64'h8000_0000, 5'd5, 1, 64'h11);
        tick();
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 64'h11}) begin
            n_err++;
            $display("FAIL b2b_first: got wen=%b addr=%0d data=%h want 1/5/11",
                     rf_wen, rf_waddr, rf_wdata);
        end
        set_op(64'h8000_0004, 5'd6, 1, 64'h22);
        tick();
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata, byp_valid, byp_addr, byp_data} !==
            {1'b1, 5'd6, 64'h22, 1'b1, 5'd6, 64'h22}) begin
            n_err++;
            $display("FAIL b2b_second: got wen=%b addr=%0d data=%h byp=%b/%0d/%h want 1/6/22",
                     rf_wen, rf_waddr, rf_wdata, byp_valid, byp_addr, byp_data);
        end
        idle();
        tick();
        n_cmp++;
        if (rf_wen !== 1'b0 || instret !== 64'd2) begin
            n_err++;
            $display("FAIL b2b_instret: got wen=%b instret=%0d want 0/2",
                     rf_wen, instret);
        end
    endtask

    task automatic test_wdata_select();
        set_op(64'h8000_0010, 5'd10, 1, 64'h8000_0000);
        ls_readflag = 1; ls_csrflag = 1;
        ls_lsures = 64'hFFFF_FFFF_FFFF_FF80;
        tick();
        n_cmp++;
        if (rf_wdata !== 64'hFFFF_FFFF_FFFF_FF80 || rf_waddr !== 5'd10) begin
            n_err++;
            $display("FAIL load_wdata: got %h addr %0d want ffffffffffffff80 addr 10",
                     rf_wdata, rf_waddr);
        end
        set_op(64'h8000_0014, 5'd11, 1, 64'h9999);
        ls_csrflag = 1; csr_rdata = 64'h1800;
        tick();
        n_cmp++;
        if (rf_wdata !== 64'h1800 || rf_wen !== 1'b1) begin
            n_err++;
            $display("FAIL csr_wdata: got %h wen %b want 1800 wen 1",
                     rf_wdata, rf_wen);
        end
    endtask

    task automatic test_x0();
        logic [63:0] c;
        idle(); tick();
        c = instret;
        set_op(64'h8000_0020, 5'd0, 1, 64'hDEAD);
        tick();
        n_cmp++;
        if ({rf_wen, byp_valid, commit_valid} !== 3'b001) begin
            n_err++;
            $display("FAIL x0_write: got wen=%b byp=%b commit=%b want 0/0/1",
                     rf_wen, byp_valid, commit_valid);
        end
        idle(); tick();
        n_cmp++;
        if (instret !== c + 64'd1) begin
            n_err++;
            $display("FAIL x0_instret: got %0d want %0d", instret, c + 64'd1);
        end
    endtask

    task automatic test_flush();
        logic [63:0] c;
        idle(); tick();
        c = instret;
        set_op(64'h8000_0030, 5'd7, 1, 64'h77);
        ls_flush = 1;
        tick();
        n_cmp++;
        if (commit_valid !== 1'b0 || rf_wen !== 1'b0) begin
            n_err++;
            $display("FAIL flush_bubble: got commit=%b wen=%b want 0/0",
                     commit_valid, rf_wen);
        end
        idle(); tick();
        n_cmp++;
        if (instret !== c) begin
            n_err++;
            $display("FAIL flush_instret: got %0d want %0d", instret, c);
        end
    endtask

    task automatic test_skipref();
        set_op(64'hA000_0000, 5'd0, 0, 64'h0);
        ls_skipref = 1;
        tick();
        n_cmp++;
        if ({commit_valid, commit_skipref, commit_pc} !==
            {1'b1, 1'b1, 64'hA000_0000}) begin
            n_err++;
            $display("FAIL skipref: got commit=%b skip=%b pc=%h want 1/1/a0000000",
                     commit_valid, commit_skipref, commit_pc);
        end
        idle(); tick();
        n_cmp++;
        if (commit_skipref !== 1'b1 && commit_valid !== 1'b0) begin
            n_err++;
            $display("FAIL skipref_after: got commit=%b want 0", commit_valid);
        end
    endtask

    task automatic test_ebreak();
        do_reset();
        set_op(64'h8000_0100, 5'd1, 1, 64'h42);
        ls_ebreak = 1;
        tick();
        n_cmp++;
        if ({commit_valid, commit_pc, halted, halt_pc, ready_ls, rf_wen} !==
            {1'b1, 64'h8000_0100, 1'b1, 64'h8000_0100, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL ebreak_commit: got commit=%b pc=%h halted=%b halt_pc=%h ready=%b wen=%b want 1/80000100/1/80000100/0/1",
                     commit_valid, commit_pc, halted, halt_pc, ready_ls, rf_wen);
        end
        for (int i = 0; i < 3; i++) begin
            set_op(64'h8000_0200 + 64'(i * 4), 5'd2, 1, 64'h5);
            tick();
            n_cmp++;
            if (commit_valid !== 1'b0 || halted !== 1'b1) begin
                n_err++;
                $display("FAIL halt_ignore: cycle %0d commit=%b halted=%b want 0/1",
                         i, commit_valid, halted);
            end
        end
        reset = 1; idle(); tick(); reset = 0;
        n_cmp++;
        if ({halted, ready_ls, instret, halt_pc} !== {1'b0, 1'b1, 64'd0, 64'd0}) begin
            n_err++;
            $display("FAIL halt_reset: got halted=%b ready=%b instret=%0d halt_pc=%h want 0/1/0/0",
                     halted, ready_ls, instret, halt_pc);
        end
        reset = 1;
        set_op(64'h8000_0300, 5'd1, 1, 64'h1);
        ls_ebreak = 1;
        tick();
        reset = 0; idle(); tick();
        n_cmp++;
        if ({halted, ready_ls, commit_valid} !== 3'b010) begin
            n_err++;
            $display("FAIL ebreak_with_reset: got halted=%b ready=%b commit=%b want 0/1/0",
                     halted, ready_ls, commit_valid);
        end
    endtask

    task automatic test_random();
        int halt_cycles;
        halt_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(99) < 2) || (halt_cycles > 4);
            set_op({$urandom, $urandom}, 5'($urandom_range(31)),
                   1'($urandom), {$urandom, $urandom});
            if ($urandom_range(3) == 0) ls_wdaddr = 5'd0;
            ls_valid = ($urandom_range(9) < 7);
            ls_flush = ($urandom_range(9) < 2);
            ls_readflag = 1'($urandom);
            ls_csrflag = 1'($urandom);
            ls_ebreak = ($urandom_range(99) < 3);
            ls_skipref = 1'($urandom);
            halt_cycles = m_halted ? halt_cycles + 1 : 0;
            tick();
            n_cmp++;
            if ({ready_ls, halted, halt_pc, commit_valid} !==
                {!m_halted, m_halted, m_halt_pc, e_v}) begin
                n_err++;
                $display("FAIL rnd_ctrl: cyc %0d got ready=%b halted=%b halt_pc=%h commit=%b want %b/%b/%h/%b",
                         i, ready_ls, halted, halt_pc, commit_valid,
                         !m_halted, m_halted, m_halt_pc, e_v);
            end
            n_cmp++;
            if (rf_wen !== (e_v && e_wen && e_waddr != 0) || byp_valid !== rf_wen) begin
                n_err++;
                $display("FAIL rnd_wen: cyc %0d got wen=%b byp=%b want %b",
                         i, rf_wen, byp_valid, e_v && e_wen && e_waddr != 0);
            end
            if (e_v) begin
                n_cmp++;
                if ({commit_pc, commit_inst, commit_nextpc, commit_skipref,
                     rf_waddr, rf_wdata, byp_addr, byp_data} !==
                    {e_pc, e_inst, e_npc, e_skip, e_waddr, e_wd, e_waddr, e_wd}) begin
                    n_err++;
                    $display("FAIL rnd_commit: cyc %0d got pc=%h inst=%h npc=%h skip=%b rd=%0d wd=%h want %h/%h/%h/%b/%0d/%h",
                             i, commit_pc, commit_inst, commit_nextpc, commit_skipref,
                             rf_waddr, rf_wdata, e_pc, e_inst, e_npc, e_skip, e_waddr, e_wd);
                end
            end else begin
                n_cmp++;
                if (instret !== m_cnt) begin
                    n_err++;
                    $display("FAIL rnd_instret: cyc %0d got %0d want %0d",
                             i, instret, m_cnt);
                end
            end
        end
        reset = 0; idle(); tick();
    endtask

    initial begin
        m_halted = 0; m_halt_pc = 0; m_cnt = 0; e_v = 0;
        e_wen = 0; e_skip = 0; e_waddr = 0; e_wd = 0; e_pc = 0; e_npc = 0; e_inst = 0;
        reset = 1;
        idle();
        tick();
        tick();
        reset = 0;
        test_reset();
        test_back_to_back();
        test_wdata_select();
        test_x0();
        test_flush();
        test_skipref();
        test_ebreak();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
